d_bus_master: RTL and testbench

//  AXI4-Lite initiator for the CPU data-memory port (address/read_enable/write_enable/...), covering both read and write.

---
 rtl/rvcore_axi_pkg.sv | 23 ++
 rtl/d_bus_master.sv | 111 +++++++++++
 tb/tb_d_bus_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvcore_axi_pkg.sv
// rvcore_axi_pkg: AXI4-Lite response codes, protection constants and data-bus master states
package rvcore_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [2:0] PROT_INSTR = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } dbus_state_t;

endpackage

// File: rtl/d_bus_master.sv
// d_bus_master: AXI4-Lite initiator for the CPU data port, one outstanding read or write
module d_bus_master
    import rvcore_axi_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter int         STRB_W = DATA_W / 8,
    parameter logic [2:0] PROT   = PROT_DATA
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_enable,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic [STRB_W-1:0] write_wstrb,
    output logic              write_done,
    output logic              bus_error,
    output logic              busy,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    dbus_state_t       state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic              is_wr;
    logic              accept_wr, accept_rd, aw_done, w_done;

    assign accept_wr = (state == IDLE) && write_enable;
    assign accept_rd = (state == IDLE) && !write_enable && read_enable;
    // a channel is finished once its valid has dropped or is handshaking now
    assign aw_done   = !awvalid || awready;
    assign w_done    = !wvalid || wready;

    assign awaddr = addr_q & ~ADDR_W'(3);
    assign araddr = awaddr;
    assign awprot = PROT;
    assign arprot = PROT;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = write_enable ? WR_REQ : (read_enable ? RD_ADDR : IDLE);
            WR_REQ:  state_nx = (aw_done && w_done) ? WR_RESP : WR_REQ;
            WR_RESP: state_nx = bvalid ? DONE : WR_RESP;
            RD_ADDR: state_nx = arready ? RD_DATA : RD_ADDR;
            RD_DATA: state_nx = rvalid ? DONE : RD_DATA;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            arvalid    <= 1'b0;
            bready     <= 1'b0;
            rready     <= 1'b0;
            busy       <= 1'b0;
            read_valid <= 1'b0;
            write_done <= 1'b0;
            bus_error  <= 1'b0;
            is_wr      <= 1'b0;
            addr_q     <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            read_data  <= '0;
        end else begin
            state      <= state_nx;
            awvalid    <= accept_wr || (awvalid && !awready);
            wvalid     <= accept_wr || (wvalid && !wready);
            arvalid    <= state_nx == RD_ADDR;
            bready     <= state_nx == WR_RESP;
            rready     <= state_nx == RD_DATA;
            busy       <= state_nx != IDLE;
            write_done <= (state_nx == DONE) && is_wr;
            read_valid <= (state_nx == DONE) && !is_wr;
            bus_error  <= (state_nx == DONE) && ((state == WR_RESP ? bresp : rresp) != OKAY);
            if (accept_wr || accept_rd) begin
                addr_q <= address;
                is_wr  <= accept_wr;
            end
            if (accept_wr) begin
                wdata <= write_data;
                wstrb <= write_wstrb;
            end
            if (state == RD_DATA && rvalid) read_data <= rdata;
        end
    end

endmodule

// File: tb/tb_d_bus_master.sv
// tb_d_bus_master: directed scenarios for the data-bus AXI4-Lite master with a small write memory
module tb_d_bus_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        read_valid;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic [3:0]  write_wstrb = '0;
    logic        write_done;
    logic        bus_error;
    logic        busy;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    int checks = 0;
    int failures = 0;
    int ar_cnt = 0;
    int wd_cnt = 0;
    int stab_viol = 0;
    logic [31:0] mem [256];
    logic [31:0] cap_addr, cap_data, p_awaddr, p_araddr, p_wdata;
    logic [3:0]  cap_strb;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;

    d_bus_master dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read_enable(read_enable),
        .read_data(read_data), .read_valid(read_valid), .write_enable(write_enable),
        .write_data(write_data), .write_wstrb(write_wstrb), .write_done(write_done),
        .bus_error(bus_error), .busy(busy), .awaddr(awaddr), .awprot(awprot),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
        .bready(bready), .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    // slave-side observer: byte-lane memory, handshake counters, stability while valid waits
    always @(posedge clk) begin
        if (awvalid && awready) cap_addr = awaddr;
        if (wvalid && wready) begin
            cap_data = wdata;
            cap_strb = wstrb;
        end
        if (bvalid && bready)
            for (int i = 0; i < 4; i++)
                if (cap_strb[i]) mem[cap_addr[9:2]][8*i +: 8] = cap_data[8*i +: 8];
        if (arvalid && arready) ar_cnt++;
        if (write_done) wd_cnt++;
        if (p_aw && awvalid && awaddr !== p_awaddr) stab_viol++;
        if (p_w && wvalid && wdata !== p_wdata) stab_viol++;
        if (p_ar && arvalid && araddr !== p_araddr) stab_viol++;
        if (reset_n && ((p_aw && !awvalid) || (p_w && !wvalid) || (p_ar && !arvalid))) stab_viol++;
        p_aw = awvalid && !awready;
        p_w  = wvalid && !wready;
        p_ar = arvalid && !arready;
        p_awaddr = awaddr;
        p_wdata  = wdata;
        p_araddr = araddr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        write_enable = 1'b1;
        read_enable  = 1'b1;
        repeat (3) tick();
        if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin failures++; $display("FAIL rst_valids got=%b exp=00000", {awvalid, wvalid, arvalid, bready, rready}); end
        checks++;
        if ({read_valid, write_done, bus_error, busy} !== 4'b0) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", {read_valid, write_done, bus_error, busy}); end
        checks++;
        if (read_data !== 32'h0) begin failures++; $display("FAIL rst_read_data got=%h exp=00000000", read_data); end
        checks++;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
        checks++;
    endtask

    task automatic test_write_basic();
        address = 32'h1000_0006; write_data = 32'hDEADBEEF; write_wstrb = 4'b1100;
        write_enable = 1'b1; awready = 1'b1; wready = 1'b1;
        tick();
        write_enable = 1'b0;
        if ({awvalid, wvalid, busy} !== 3'b111) begin failures++; $display("FAIL wr_valids got=%b exp=111", {awvalid, wvalid, busy}); end
        checks++;
        if (awaddr !== 32'h1000_0004) begin failures++; $display("FAIL wr_awaddr got=%h exp=10000004", awaddr); end
        checks++;
        if ({wdata, wstrb, awprot} !== {32'hDEADBEEF, 4'b1100, 3'b000}) begin failures++; $display("FAIL wr_wdata got=%h/%b/%b exp=deadbeef/1100/000", wdata, wstrb, awprot); end
        checks++;
        tick();
        if ({awvalid, wvalid, bready, write_done} !== 4'b0010) begin failures++; $display("FAIL wr_bready got=%b exp=0010", {awvalid, wvalid, bready, write_done}); end
        checks++;
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        if ({write_done, bus_error, read_valid} !== 3'b100) begin failures++; $display("FAIL wr_done got=%b exp=100", {write_done, bus_error, read_valid}); end
        checks++;
        tick();
        if ({write_done, busy} !== 2'b00) begin failures++; $display("FAIL wr_done_end got=%b exp=00", {write_done, busy}); end
        checks++;
        if (mem[1] !== 32'hDEAD0000) begin failures++; $display("FAIL wr_mem got=%h exp=dead0000", mem[1]); end
        checks++;
        awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_skewed_write();
        int base;
        base = wd_cnt;
        address = 32'h3000_0008; write_data = 32'hCAFEF00D; write_wstrb = 4'b1111;
        write_enable = 1'b1; awready = 1'b0; wready = 1'b1;
        tick();
        write_enable = 1'b0;
        if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("FAIL skew_start got=%b exp=11", {awvalid, wvalid}); end
        checks++;
        tick();
        if ({awvalid, wvalid, bready} !== 3'b100) begin failures++; $display("FAIL skew_c2 got=%b exp=100", {awvalid, wvalid, bready}); end
        checks++;
        tick();
        if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h3000_0008) begin failures++; $display("FAIL skew_c3 got=%b/%h exp=100/30000008", {awvalid, wvalid, bready}, awaddr); end
        checks++;
        awready = 1'b1;
        tick();
        awready = 1'b0;
        if ({awvalid, bready} !== 2'b01) begin failures++; $display("FAIL skew_bready got=%b exp=01", {awvalid, bready}); end
        checks++;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        if (write_done !== 1'b1) begin failures++; $display("FAIL skew_done got=%b exp=1", write_done); end
        checks++;
        tick();
        if (wd_cnt - base !== 1) begin failures++; $display("FAIL skew_done_count got=%0d exp=1", wd_cnt - base); end
        checks++;
        if (mem[2] !== 32'hCAFEF00D) begin failures++; $display("FAIL skew_mem got=%h exp=cafef00d", mem[2]); end
        checks++;
        wready = 1'b0;
    endtask

    task automatic test_read();
        int base;
        base = ar_cnt;
        address = 32'h0000_2000; read_enable = 1'b1; arready = 1'b1;
        tick();
        if ({arvalid, awvalid} !== 2'b10 || araddr !== 32'h2000) begin failures++; $display("FAIL rd_ar got=%b/%h exp=10/00002000", {arvalid, awvalid}, araddr); end
        checks++;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({arvalid, rready, read_valid} !== 3'b010) begin failures++; $display("FAIL rd_wait%0d got=%b exp=010", i, {arvalid, rready, read_valid}); end
            checks++;
            tick();
        end
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
        if ({read_valid, bus_error, write_done} !== 3'b100 || read_data !== 32'h12345678) begin failures++; $display("FAIL rd_valid got=%b/%h exp=100/12345678", {read_valid, bus_error, write_done}, read_data); end
        checks++;
        tick();
        read_enable = 1'b0;
        if ({read_valid, busy} !== 2'b00 || read_data !== 32'h12345678) begin failures++; $display("FAIL rd_hold got=%b/%h exp=00/12345678", {read_valid, busy}, read_data); end
        checks++;
        arready = 1'b1;
        repeat (3) tick();
        arready = 1'b0;
        if (ar_cnt - base !== 1 || busy !== 1'b0) begin failures++; $display("FAIL rd_single_ar got=%0d/%b exp=1/0", ar_cnt - base, busy); end
        checks++;
    endtask

    task automatic test_both_and_errors();
        int base;
        base = ar_cnt;
        address = 32'h0000_0040; write_data = 32'h11223344; write_wstrb = 4'b0001;
        write_enable = 1'b1; read_enable = 1'b1; awready = 1'b1; wready = 1'b1; arready = 1'b1;
        tick();
        write_enable = 1'b0; read_enable = 1'b0;
        if ({awvalid, wvalid, arvalid} !== 3'b110) begin failures++; $display("FAIL both_priority got=%b exp=110", {awvalid, wvalid, arvalid}); end
        checks++;
        tick();
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        if ({write_done, bus_error, read_valid} !== 3'b110) begin failures++; $display("FAIL both_berr got=%b exp=110", {write_done, bus_error, read_valid}); end
        checks++;
        tick();
        if (bus_error !== 1'b0 || ar_cnt !== base) begin failures++; $display("FAIL both_no_ar got=%b/%0d exp=0/%0d", bus_error, ar_cnt, base); end
        checks++;
        if (mem[16] !== 32'h0000_0044) begin failures++; $display("FAIL both_mem got=%h exp=00000044", mem[16]); end
        checks++;
        awready = 1'b0; wready = 1'b0;
        address = 32'h0000_0044; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'hA5A5A5A5; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        if ({read_valid, bus_error, write_done} !== 3'b110 || read_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL rd_slverr got=%b/%h exp=110/a5a5a5a5", {read_valid, bus_error, write_done}, read_data); end
        checks++;
        tick();
        if ({read_valid, bus_error} !== 2'b00) begin failures++; $display("FAIL rd_slverr_end got=%b exp=00", {read_valid, bus_error}); end
        checks++;
        arready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        base = ar_cnt;
        address = 32'h0000_5000; read_enable = 1'b1; arready = 1'b0;
        tick();
        read_enable = 1'b0;
        tick();
        if ({arvalid, busy} !== 2'b11) begin failures++; $display("FAIL mid_pending got=%b exp=11", {arvalid, busy}); end
        checks++;
        reset_n = 1'b0;
        #1;
        if ({arvalid, busy, rready} !== 3'b000) begin failures++; $display("FAIL mid_async got=%b exp=000", {arvalid, busy, rready}); end
        checks++;
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        address = 32'h0000_6000; read_enable = 1'b1; arready = 1'b1;
        tick();
        read_enable = 1'b0;
        if (arvalid !== 1'b1 || araddr !== 32'h6000) begin failures++; $display("FAIL mid_restart got=%b/%h exp=1/00006000", arvalid, araddr); end
        checks++;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0BADF00D;
        tick();
        rvalid = 1'b0;
        if (read_valid !== 1'b1 || read_data !== 32'h0BADF00D || ar_cnt - base !== 1) begin failures++; $display("FAIL mid_read got=%b/%h/%0d exp=1/0badf00d/1", read_valid, read_data, ar_cnt - base); end
        checks++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_write_basic();
        test_skewed_write();
        test_read();
        test_both_and_errors();
        test_reset_mid();
        if (stab_viol !== 0) begin failures++; $display("FAIL axi_stability got=%0d exp=0", stab_viol); end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
